// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload with minimum-length padding,
// optional CRC32 FCS, inter-frame gap and underrun abort.
module eth_tx_framer #(
  parameter int unsigned IFG_BYTES       = 12,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter bit          APPEND_FCS      = 1'b1
) (
  input  logic       clkIn,
  input  logic       rstIn,
  input  logic [7:0] dataIn,
  input  logic       dataValidIn,
  input  logic       dataLastIn,
  output logic       dataReadyOut,
  output logic [7:0] txDataOut,
  output logic       txEnOut,
  output logic       txErOut,
  output logic       busyOut,
  output logic       underrunOut
);

  // state      | meaning
  // S_IDLE     | waiting for dataValidIn, counters and CRC held at start values
  // S_PREAMBLE | seven 0x55 bytes
  // S_SFD      | one 0xD5 byte
  // S_PAYLOAD  | forwarding accepted bytes, underrun aborts the frame
  // S_PAD      | 0x00 bytes until the minimum length is reached
  // S_FCS      | four inverted-CRC bytes, LSB first
  // S_IFG      | IFG_BYTES idle byte times, input ignored
  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [7:0]  IFG_TMR   = 8'(IFG_BYTES - 1);
  localparam logic [10:0] MIN_CNT   = 11'(MIN_FRAME_BYTES);
  localparam state_t      END_STATE = APPEND_FCS ? S_FCS : S_IFG;
  localparam logic [7:0]  END_TMR   = APPEND_FCS ? 8'd3 : IFG_TMR;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_tmr, w_tmr_nxt;
  logic [10:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [31:0] r_crc, w_crc_nxt, w_crc_upd;
  logic [7:0]  w_crc_byte;
  logic [7:0]  r_txd, w_txd_nxt;
  logic        r_txen, w_txen_nxt;
  logic        r_txer, w_txer_nxt;
  logic        r_unr, w_unr_nxt;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h000000, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  assign w_cnt_inc    = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
  assign w_crc_byte   = (r_state == S_PAYLOAD) ? dataIn : 8'h00;
  assign w_crc_upd    = crc32_byte(r_crc, w_crc_byte);
  assign dataReadyOut = (r_state == S_PAYLOAD);
  assign busyOut      = (r_state != S_IDLE);
  assign txDataOut    = r_txd;
  assign txEnOut      = r_txen;
  assign txErOut      = r_txer;
  assign underrunOut  = r_unr;

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Output registers carry the byte chosen by the state active at the edge.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_cnt_nxt   = r_cnt;
    w_crc_nxt   = r_crc;
    w_txd_nxt   = 8'h00;
    w_txen_nxt  = 1'b0;
    w_txer_nxt  = 1'b0;
    w_unr_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_crc_nxt = 32'hFFFFFFFF;
        w_tmr_nxt = 8'd6;
        if (dataValidIn) w_state_nxt = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        w_txen_nxt = 1'b1;
        w_txd_nxt  = 8'h55;
        if (r_tmr == 8'd0) w_state_nxt = S_SFD;
        else               w_tmr_nxt   = r_tmr - 8'd1;
      end
      S_SFD: begin
        w_txen_nxt  = 1'b1;
        w_txd_nxt   = 8'hD5;
        w_state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_txen_nxt = 1'b1;
        if (dataValidIn) begin
          w_txd_nxt = dataIn;
          w_cnt_nxt = w_cnt_inc;
          w_crc_nxt = w_crc_upd;
          if (dataLastIn) begin
            if (w_cnt_inc < MIN_CNT) begin
              w_state_nxt = S_PAD;
            end else begin
              w_state_nxt = END_STATE;
              w_tmr_nxt   = END_TMR;
            end
          end
        end else begin
          w_txer_nxt  = 1'b1;
          w_unr_nxt   = 1'b1;
          w_state_nxt = S_IFG;
          w_tmr_nxt   = IFG_TMR;
        end
      end
      S_PAD: begin
        w_txen_nxt = 1'b1;
        w_cnt_nxt  = w_cnt_inc;
        w_crc_nxt  = w_crc_upd;
        if (w_cnt_inc >= MIN_CNT) begin
          w_state_nxt = END_STATE;
          w_tmr_nxt   = END_TMR;
        end
      end
      S_FCS: begin
        // CRC is shifted down so the next FCS byte always sits in the low byte.
        w_txen_nxt = 1'b1;
        w_txd_nxt  = ~r_crc[7:0];
        w_crc_nxt  = {8'h00, r_crc[31:8]};
        if (r_tmr == 8'd0) begin
          w_state_nxt = S_IFG;
          w_tmr_nxt   = IFG_TMR;
        end else begin
          w_tmr_nxt = r_tmr - 8'd1;
        end
      end
      S_IFG: begin
        if (r_tmr == 8'd0) w_state_nxt = S_IDLE;
        else               w_tmr_nxt   = r_tmr - 8'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_tmr  <= '0;
      r_cnt  <= '0;
      r_crc  <= 32'hFFFFFFFF;
      r_txd  <= 8'h00;
      r_txen <= 1'b0;
      r_txer <= 1'b0;
      r_unr  <= 1'b0;
    end else begin
      r_tmr  <= w_tmr_nxt;
      r_cnt  <= w_cnt_nxt;
      r_crc  <= w_crc_nxt;
      r_txd  <= w_txd_nxt;
      r_txen <= w_txen_nxt;
      r_txer <= w_txer_nxt;
      r_unr  <= w_unr_nxt;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: randomized frames compared against a
// frame-level reference (preamble, padded payload, CRC32 FCS, gap timing).
`timescale 1ns/1ps
module tb_eth_tx_framer;

  typedef bit [7:0] bq_t[$];
  typedef int iq_t[$];
  typedef struct { bit en; bit er; bit [7:0] d; bit unr; bit rdy; } smp_t;
  typedef smp_t sq_t[$];
  typedef struct { bit [7:0] d; bit last; bit gap; } item_t;

  logic       clkIn = 1'b0;
  logic       rstIn = 1'b1;
  logic [7:0] dataIn = 8'h00;
  logic       dataValidIn = 1'b0;
  logic       dataLastIn = 1'b0;
  logic       dataReadyOut, txEnOut, txErOut, busyOut, underrunOut;
  logic [7:0] txDataOut;
  logic       n_dataReadyOut, n_txEnOut, n_txErOut, n_busyOut, n_underrunOut;
  logic [7:0] n_txDataOut;

  int    checks = 0;
  int    errors = 0;
  bit    mon_on = 1'b0;
  sq_t   mon_q, mon2_q;
  item_t stream[$];

  eth_tx_framer dut (
    .clkIn(clkIn), .rstIn(rstIn), .dataIn(dataIn), .dataValidIn(dataValidIn),
    .dataLastIn(dataLastIn), .dataReadyOut(dataReadyOut), .txDataOut(txDataOut),
    .txEnOut(txEnOut), .txErOut(txErOut), .busyOut(busyOut), .underrunOut(underrunOut)
  );

  eth_tx_framer #(.APPEND_FCS(1'b0)) dut_nofcs (
    .clkIn(clkIn), .rstIn(rstIn), .dataIn(dataIn), .dataValidIn(dataValidIn),
    .dataLastIn(dataLastIn), .dataReadyOut(n_dataReadyOut), .txDataOut(n_txDataOut),
    .txEnOut(n_txEnOut), .txErOut(n_txErOut), .busyOut(n_busyOut), .underrunOut(n_underrunOut)
  );

  initial forever #5 clkIn = ~clkIn;

  always @(negedge clkIn) begin : mon_blk
    smp_t s;
    if (mon_on) begin
      s.en = txEnOut; s.er = txErOut; s.d = txDataOut; s.unr = underrunOut; s.rdy = dataReadyOut;
      mon_q.push_back(s);
      s.en = n_txEnOut; s.er = n_txErOut; s.d = n_txDataOut; s.unr = n_underrunOut; s.rdy = n_dataReadyOut;
      mon2_q.push_back(s);
    end
  end

  // Bit-serial reflected CRC32.
  function automatic bit [31:0] crc_step(input bit [31:0] c, input bit [7:0] b);
    bit [31:0] r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return crc_step_ret(r);
  endfunction

  function automatic bit [31:0] crc_step_ret(input bit [31:0] r);
    return r;
  endfunction

  task automatic build_frame(input bq_t pl, input bit fcs, output bq_t fr);
    bit [31:0] c;
    fr = {};
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    foreach (pl[i]) fr.push_back(pl[i]);
    while (fr.size() < 68) fr.push_back(8'h00);
    if (fcs) begin
      c = 32'hFFFFFFFF;
      for (int i = 8; i < fr.size(); i++) c = crc_step(c, fr[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
    end
  endtask

  task automatic get_runs(input sq_t q, output iq_t st, output iq_t ln);
    int i = 0;
    st = {}; ln = {};
    while (i < q.size()) begin
      if (q[i].en) begin
        int s = i;
        while (i < q.size() && q[i].en) i++;
        st.push_back(s);
        ln.push_back(i - s);
      end else begin
        i++;
      end
    end
  endtask

  function automatic int run_diffs(input sq_t q, input int st, input bq_t ex);
    int d = 0;
    foreach (ex[i]) begin
      if (st + i >= q.size()) d++;
      else if (!q[st+i].en || q[st+i].er || q[st+i].d != ex[i]) d++;
    end
    return d;
  endfunction

  task automatic rand_payload(input int n, output bq_t pl);
    pl = {};
    repeat (n) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic add_frame(input bq_t pl, input int gap_idx);
    foreach (pl[i]) begin
      item_t it;
      it.d = pl[i]; it.last = (i == pl.size() - 1); it.gap = (i == gap_idx);
      stream.push_back(it);
    end
  endtask

  task automatic drive_stream(input int abort_after);
    int idx = 0;
    int budget = 0;
    bit gap_done = 1'b0;
    while (idx < stream.size() && idx != abort_after) begin
      @(negedge clkIn);
      budget++;
      if (budget > 6000) begin
        checks++; errors++;
        $display("FAIL drive_timeout: transferred %0d required %0d", idx, stream.size());
        break;
      end
      if (stream[idx].gap && !gap_done) begin
        dataValidIn = 1'b0;
        gap_done = 1'b1;
      end else begin
        dataIn = stream[idx].d; dataLastIn = stream[idx].last; dataValidIn = 1'b1;
        if (dataReadyOut) begin idx++; gap_done = 1'b0; end
      end
    end
    @(negedge clkIn);
    dataValidIn = 1'b0; dataLastIn = 1'b0;
  endtask

  task automatic start_mon();
    mon_q = {}; mon2_q = {}; stream = {};
    mon_on = 1'b1;
  endtask

  task automatic finish_mon();
    int n = 0;
    while ((busyOut || n_busyOut) && n < 3000) begin @(negedge clkIn); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy after %0d cycles, required idle", n);
    end
    repeat (3) @(negedge clkIn);
    mon_on = 1'b0;
  endtask

  task automatic test_reset();
    rstIn = 1'b1; dataValidIn = 1'b1;
    repeat (2) @(negedge clkIn);
    checks++; if (txEnOut !== 1'b0) begin errors++; $display("FAIL reset_txen: got %b expected 0", txEnOut); end
    checks++; if (txErOut !== 1'b0) begin errors++; $display("FAIL reset_txer: got %b expected 0", txErOut); end
    checks++; if (txDataOut !== 8'h00) begin errors++; $display("FAIL reset_txd: got %h expected 00", txDataOut); end
    checks++; if (dataReadyOut !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", dataReadyOut); end
    checks++; if (busyOut !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busyOut); end
    checks++; if (underrunOut !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrunOut); end
    #2 rstIn = 1'b0;
    #2;
    checks++; if (busyOut !== 1'b0 || txEnOut !== 1'b0) begin
      errors++; $display("FAIL reset_release: busy %b txen %b before edge, expected 0 0", busyOut, txEnOut);
    end
    dataValidIn = 1'b0;
    @(negedge clkIn);
  endtask

  task automatic test_frame_64();
    bq_t pl, ex; iq_t st, ln; bit [31:0] c; int unr = 0;
    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    start_mon(); add_frame(pl, -1); drive_stream(-1); finish_mon();
    build_frame(pl, 1'b1, ex);
    get_runs(mon_q, st, ln);
    foreach (mon_q[i]) if (mon_q[i].unr) unr++;
    checks++; if (st.size() != 1) begin errors++; $display("FAIL f64_runs: got %0d expected 1", st.size()); end
    checks++; if (unr != 0) begin errors++; $display("FAIL f64_underrun: got %0d pulses expected 0", unr); end
    if (st.size() > 0) begin
      checks++; if (ln[0] != 76) begin errors++; $display("FAIL f64_len: got %0d expected 76", ln[0]); end
      checks++; if (run_diffs(mon_q, st[0], ex) != 0) begin
        errors++; $display("FAIL f64_bytes: got %0d bad bytes expected 0", run_diffs(mon_q, st[0], ex));
      end
      c = 32'hFFFFFFFF;
      for (int i = 8; i < 76 && st[0] + i < mon_q.size(); i++) c = crc_step(c, mon_q[st[0]+i].d);
      checks++; if (c !== 32'hDEBB20E3) begin errors++; $display("FAIL f64_residue: got %h expected DEBB20E3", c); end
    end
  endtask

  task automatic test_short_10();
    bq_t pl, ex; iq_t st, ln;
    rand_payload(10, pl);
    start_mon(); add_frame(pl, -1); drive_stream(-1); finish_mon();
    build_frame(pl, 1'b1, ex);
    get_runs(mon_q, st, ln);
    checks++; if (st.size() != 1) begin errors++; $display("FAIL short_runs: got %0d expected 1", st.size()); end
    if (st.size() > 0) begin
      checks++; if (ln[0] != 72) begin errors++; $display("FAIL short_len: got %0d expected 72", ln[0]); end
      checks++; if (run_diffs(mon_q, st[0], ex) != 0) begin
        errors++; $display("FAIL short_bytes: got %0d bad bytes expected 0", run_diffs(mon_q, st[0], ex));
      end
    end
  endtask

  task automatic test_random_frames();
    int lens[6] = '{59, 60, 61, 0, 0, 0};
    for (int f = 3; f < 6; f++) lens[f] = $urandom_range(1, 120);
    for (int f = 0; f < 6; f++) begin
      bq_t pl, ex; iq_t st, ln;
      rand_payload(lens[f], pl);
      repeat ($urandom_range(0, 4)) @(negedge clkIn);
      start_mon(); add_frame(pl, -1); drive_stream(-1); finish_mon();
      build_frame(pl, 1'b1, ex);
      get_runs(mon_q, st, ln);
      checks++; if (st.size() != 1 || ln[0] != ex.size()) begin
        errors++; $display("FAIL rand_len[%0d]: got %0d runs len %0d expected 1 run len %0d",
                           lens[f], st.size(), (st.size() > 0) ? ln[0] : 0, ex.size());
      end else if (run_diffs(mon_q, st[0], ex) != 0) begin
        errors++; $display("FAIL rand_bytes[%0d]: got %0d bad bytes expected 0", lens[f], run_diffs(mon_q, st[0], ex));
      end
    end
  endtask

  task automatic test_back_to_back();
    bq_t p0, p1, e0, e1; iq_t st, ln;
    rand_payload(60, p0); rand_payload(60, p1);
    start_mon(); add_frame(p0, -1); add_frame(p1, -1); drive_stream(-1); finish_mon();
    build_frame(p0, 1'b1, e0); build_frame(p1, 1'b1, e1);
    get_runs(mon_q, st, ln);
    checks++; if (st.size() != 2) begin errors++; $display("FAIL b2b_runs: got %0d expected 2", st.size()); end
    if (st.size() == 2) begin
      checks++; if (ln[0] != 72 || ln[1] != 72) begin errors++; $display("FAIL b2b_len: got %0d,%0d expected 72,72", ln[0], ln[1]); end
      checks++; if (st[1] - (st[0] + ln[0]) != 13) begin
        errors++; $display("FAIL b2b_gap: got %0d idle cycles expected 13", st[1] - (st[0] + ln[0]));
      end
      checks++; if (run_diffs(mon_q, st[0], e0) + run_diffs(mon_q, st[1], e1) != 0) begin
        errors++; $display("FAIL b2b_bytes: got %0d bad bytes expected 0", run_diffs(mon_q, st[0], e0) + run_diffs(mon_q, st[1], e1));
      end
    end
  endtask

  task automatic test_underrun();
    bq_t pl, rest, ea, eb; iq_t st, ln; int unr = 0; int n;
    n = $urandom_range(30, 50);
    rand_payload(n, pl);
    rest = pl[20:$];
    start_mon(); add_frame(pl, 20); drive_stream(-1); finish_mon();
    ea = {};
    for (int i = 0; i < 7; i++) ea.push_back(8'h55);
    ea.push_back(8'hD5);
    for (int i = 0; i < 20; i++) ea.push_back(pl[i]);
    build_frame(rest, 1'b1, eb);
    get_runs(mon_q, st, ln);
    foreach (mon_q[i]) if (mon_q[i].unr) unr++;
    checks++; if (unr != 1) begin errors++; $display("FAIL unr_pulses: got %0d expected 1", unr); end
    checks++; if (st.size() != 2) begin errors++; $display("FAIL unr_runs: got %0d expected 2", st.size()); end
    if (st.size() == 2) begin
      checks++; if (ln[0] != 29) begin errors++; $display("FAIL unr_len: got %0d expected 29", ln[0]); end
      checks++; if (run_diffs(mon_q, st[0], ea) != 0) begin
        errors++; $display("FAIL unr_head: got %0d bad bytes expected 0", run_diffs(mon_q, st[0], ea));
      end
      checks++; if (!mon_q[st[0]+28].er || !mon_q[st[0]+28].unr || mon_q[st[0]+28].d != 8'h00) begin
        errors++; $display("FAIL unr_err_cycle: got er %b unr %b d %h expected 1 1 00",
                           mon_q[st[0]+28].er, mon_q[st[0]+28].unr, mon_q[st[0]+28].d);
      end
      checks++; if (st[1] - (st[0] + ln[0]) != 13) begin
        errors++; $display("FAIL unr_gap: got %0d idle cycles expected 13", st[1] - (st[0] + ln[0]));
      end
      checks++; if (ln[1] != eb.size() || run_diffs(mon_q, st[1], eb) != 0) begin
        errors++; $display("FAIL unr_next: got len %0d expected %0d", ln[1], eb.size());
      end
    end
  endtask

  task automatic test_reset_midframe();
    bq_t pl, p2, ex; iq_t st, ln;
    rand_payload(50, pl);
    start_mon(); add_frame(pl, -1); drive_stream(30);
    checks++; if (txEnOut !== 1'b1 || txDataOut !== pl[29]) begin
      errors++; $display("FAIL rst_pre: got en %b d %h expected 1 %h", txEnOut, txDataOut, pl[29]);
    end
    #1 rstIn = 1'b1;
    #1;
    checks++; if (txEnOut !== 1'b0 || txDataOut !== 8'h00 || busyOut !== 1'b0 || dataReadyOut !== 1'b0) begin
      errors++; $display("FAIL rst_async: got en %b d %h busy %b rdy %b expected 0 00 0 0",
                         txEnOut, txDataOut, busyOut, dataReadyOut);
    end
    #1 rstIn = 1'b0;
    #1;
    checks++; if (txEnOut !== 1'b0 || busyOut !== 1'b0) begin
      errors++; $display("FAIL rst_release: got en %b busy %b expected 0 0", txEnOut, busyOut);
    end
    finish_mon();
    get_runs(mon_q, st, ln);
    checks++; if (st.size() != 1 || ln[0] != 38) begin
      errors++; $display("FAIL rst_trunc: got %0d runs len %0d expected 1 run len 38", st.size(), (st.size() > 0) ? ln[0] : 0);
    end
    rand_payload(40, p2);
    start_mon(); add_frame(p2, -1); drive_stream(-1); finish_mon();
    build_frame(p2, 1'b1, ex);
    get_runs(mon_q, st, ln);
    checks++; if (st.size() != 1 || ln[0] != 72 || run_diffs(mon_q, st[0], ex) != 0) begin
      errors++; $display("FAIL rst_next: got %0d runs len %0d expected 1 run len 72", st.size(), (st.size() > 0) ? ln[0] : 0);
    end
  endtask

  task automatic test_no_fcs();
    bq_t pl, ex; iq_t st, ln;
    rand_payload(60, pl);
    start_mon(); add_frame(pl, -1); drive_stream(-1); finish_mon();
    build_frame(pl, 1'b0, ex);
    get_runs(mon2_q, st, ln);
    checks++; if (st.size() != 1 || ln[0] != 68) begin
      errors++; $display("FAIL nofcs_len: got %0d runs len %0d expected 1 run len 68", st.size(), (st.size() > 0) ? ln[0] : 0);
    end else begin
      checks++; if (mon2_q[st[0]+67].d != pl[59]) begin
        errors++; $display("FAIL nofcs_last: got %h expected %h", mon2_q[st[0]+67].d, pl[59]);
      end
      checks++; if (run_diffs(mon2_q, st[0], ex) != 0) begin
        errors++; $display("FAIL nofcs_bytes: got %0d bad bytes expected 0", run_diffs(mon2_q, st[0], ex));
      end
    end
  endtask

  task automatic test_long_frame();
    bq_t pl, ex; iq_t st, ln;
    rand_payload(2053, pl);
    start_mon(); add_frame(pl, -1); drive_stream(-1); finish_mon();
    build_frame(pl, 1'b1, ex);
    get_runs(mon_q, st, ln);
    checks++; if (st.size() != 1 || ln[0] != 2065) begin
      errors++; $display("FAIL long_len: got %0d runs len %0d expected 1 run len 2065", st.size(), (st.size() > 0) ? ln[0] : 0);
    end else begin
      checks++; if (run_diffs(mon_q, st[0], ex) != 0) begin
        errors++; $display("FAIL long_bytes: got %0d bad bytes expected 0", run_diffs(mon_q, st[0], ex));
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_64();
    test_short_10();
    test_random_frames();
    test_back_to_back();
    test_underrun();
    test_reset_midframe();
    test_no_fcs();
    test_long_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
